// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder:
// FSM state encoding, error codes and default frame bytes.
package uart_cmd_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_LEN   = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_ISSUE = 3'd5;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_CMD  = 3'd1;
    localparam logic [2:0] ERR_BAD_LEN  = 3'd2;
    localparam logic [2:0] ERR_FIFO_OVF = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_OVERRUN  = 3'd5;

    localparam logic [7:0] DEF_SOF    = 8'h55;
    localparam logic [7:0] DEF_CMD_WR = 8'hAA;
    localparam logic [7:0] DEF_CMD_RD = 8'hA5;

    localparam int LEN_W = 8;

    // States in which the inter-byte gap is being policed
    function automatic logic in_frame(input logic [2:0] st);
        return (st == ST_CMD) || (st == ST_ADDR) ||
               (st == ST_LEN) || (st == ST_DATA);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while run is high,
// restarts on clr, flags expiry on the TIMEOUT_CYC-th idle cycle.
module gap_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Idle-cycle counter; saturates at LAST so it can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || clr) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A strobe in the expiry cycle masks the expiry
    assign expired = run && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: parses SOF/CMD/ADDR/LEN/payload frames,
// feeds the write FIFO and issues SDRAM read/write triggers.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int         ADDR_BYTES  = 3,
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF_BYTE    = DEF_SOF,
    parameter logic [7:0] CMD_WR      = DEF_CMD_WR,
    parameter logic [7:0] CMD_RD      = DEF_CMD_RD,
    parameter int         TIMEOUT_CYC = 50000,
    localparam int        ADDR_W      = 8 * ADDR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              flag_rx_end,
    input  logic              wfifo_full,
    input  logic              cmd_busy,
    output logic              wfifo_wr_en,
    output logic [7:0]        wfifo_wr_data,
    output logic              wfifo_clr,
    output logic              wr_trig,
    output logic              rd_trig,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              err_valid,
    output logic [2:0]        err_code
);

    localparam int CNT_MAX = (MAX_LEN > ADDR_BYTES) ? MAX_LEN : ADDR_BYTES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

    logic [2:0]        state;
    logic              is_wr;
    logic [ADDR_W-1:0] addr_sr;
    logic [LEN_W-1:0]  len_r;
    logic [CNT_W-1:0]  idx;
    logic              expired;
    logic              run;

    assign run = in_frame(state);

    gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clr    (flag_rx_end),
        .expired(expired)
    );

    // Frame FSM with registered outputs; pulse outputs default low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            is_wr         <= 1'b0;
            addr_sr       <= '0;
            len_r         <= '0;
            idx           <= '0;
            wfifo_wr_en   <= 1'b0;
            wfifo_wr_data <= '0;
            wfifo_clr     <= 1'b0;
            wr_trig       <= 1'b0;
            rd_trig       <= 1'b0;
            cmd_addr      <= '0;
            cmd_len       <= '0;
            err_valid     <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            wfifo_wr_en <= 1'b0;
            wfifo_clr   <= 1'b0;
            wr_trig     <= 1'b0;
            rd_trig     <= 1'b0;
            err_valid   <= 1'b0;

            if (run && !flag_rx_end && expired) begin
                err_valid <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                wfifo_clr <= (state == ST_DATA);
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (flag_rx_end && rx_data == SOF_BYTE) begin
                            idx   <= '0;
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (flag_rx_end) begin
                            if (rx_data == CMD_WR) begin
                                is_wr <= 1'b1;
                                state <= ST_ADDR;
                            end else if (rx_data == CMD_RD) begin
                                is_wr <= 1'b0;
                                state <= ST_ADDR;
                            end else begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_BAD_CMD;
                                state     <= ST_IDLE;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (flag_rx_end) begin
                            addr_sr <= (addr_sr << 8) | ADDR_W'(rx_data);
                            if (idx == ADDR_LAST) begin
                                idx   <= '0;
                                state <= ST_LEN;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    ST_LEN: begin
                        if (flag_rx_end) begin
                            if (rx_data == '0 || rx_data > LEN_MAX) begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_BAD_LEN;
                                state     <= ST_IDLE;
                            end else begin
                                len_r <= rx_data;
                                idx   <= '0;
                                state <= is_wr ? ST_DATA : ST_ISSUE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (flag_rx_end) begin
                            if (wfifo_full) begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_FIFO_OVF;
                                wfifo_clr <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                wfifo_wr_en   <= 1'b1;
                                wfifo_wr_data <= rx_data;
                                if (LEN_W'(idx) == len_r - 8'd1) begin
                                    state <= ST_ISSUE;
                                end else begin
                                    idx <= idx + 1'b1;
                                end
                            end
                        end
                    end
                    ST_ISSUE: begin
                        // A byte here has nowhere to go; report it but keep the request
                        if (flag_rx_end) begin
                            err_valid <= 1'b1;
                            err_code  <= ERR_OVERRUN;
                        end
                        if (!cmd_busy) begin
                            wr_trig  <= is_wr;
                            rd_trig  <= !is_wr;
                            cmd_addr <= addr_sr;
                            cmd_len  <= len_r;
                            state    <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder.
// Uses TIMEOUT_CYC=100 to keep timeout cases short.
module tb_uart_cmd_decoder;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        flag_rx_end = 1'b0;
    logic        wfifo_full = 1'b0;
    logic        cmd_busy = 1'b0;
    logic        wfifo_wr_en;
    logic [7:0]  wfifo_wr_data;
    logic        wfifo_clr;
    logic        wr_trig;
    logic        rd_trig;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        err_valid;
    logic [2:0]  err_code;

    uart_cmd_decoder #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .flag_rx_end  (flag_rx_end),
        .wfifo_full   (wfifo_full),
        .cmd_busy     (cmd_busy),
        .wfifo_wr_en  (wfifo_wr_en),
        .wfifo_wr_data(wfifo_wr_data),
        .wfifo_clr    (wfifo_clr),
        .wr_trig      (wr_trig),
        .rd_trig      (rd_trig),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .err_valid    (err_valid),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle
    int n_wr = 0, n_wt = 0, n_rt = 0, n_err = 0, n_clr = 0;
    int strobe_cyc = 0, wt_cyc = 0, rt_cyc = 0, err_cyc = 0;
    logic [7:0] wlog [0:255];

    always @(negedge clk) begin
        if (flag_rx_end) strobe_cyc = cyc;
        if (wfifo_wr_en) begin
            wlog[n_wr[7:0]] = wfifo_wr_data;
            n_wr = n_wr + 1;
        end
        if (wr_trig) begin
            n_wt = n_wt + 1;
            wt_cyc = cyc;
        end
        if (rd_trig) begin
            n_rt = n_rt + 1;
            rt_cyc = cyc;
        end
        if (err_valid) begin
            n_err = n_err + 1;
            err_cyc = cyc;
        end
        if (wfifo_clr) n_clr = n_clr + 1;
    end

    int total = 0;
    int bad = 0;
    int s_wr, s_wt, s_rt, s_err, s_clr;
    int lstrobe, fall_cyc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_wr  = n_wr;
        s_wt  = n_wt;
        s_rt  = n_rt;
        s_err = n_err;
        s_clr = n_clr;
    endtask

    // Caller is at posedge+1; returns at posedge+1 after the strobe
    task automatic send(input logic [7:0] b);
        rx_data = b;
        flag_rx_end = 1'b1;
        @(posedge clk);
        #1;
        flag_rx_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        check("rst_wr_en", 32'(wfifo_wr_en), 0);
        check("rst_trig", {30'd0, wr_trig, rd_trig}, 0);
        check("rst_err", {28'd0, err_valid, err_code}, 0);
        check("rst_addr", 32'(cmd_addr), 0);
        check("rst_len", 32'(cmd_len), 0);
        rst = 1'b0;
        idle(2);

        // Read frame
        snap();
        send(8'h55); send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
        send(8'h04);
        lstrobe = strobe_cyc;
        idle(5);
        check("rd_count", 32'(n_rt - s_rt), 1);
        check("rd_lat", 32'(rt_cyc - lstrobe), 2);
        check("rd_addr", 32'(cmd_addr), 32'h010203);
        check("rd_len", 32'(cmd_len), 4);
        check("rd_no_wr", 32'(n_wr - s_wr), 0);
        check("rd_no_wt", 32'(n_wt - s_wt), 0);
        check("rd_no_err", 32'(n_err - s_err), 0);

        // Write frame
        snap();
        send(8'h55); send(8'hAA); send(8'h00); send(8'h00); send(8'h10);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        lstrobe = strobe_cyc;
        idle(5);
        check("wr_push_count", 32'(n_wr - s_wr), 3);
        check("wr_d0", 32'(wlog[s_wr[7:0]]), 32'h11);
        check("wr_d1", 32'(wlog[8'(s_wr + 1)]), 32'h22);
        check("wr_d2", 32'(wlog[8'(s_wr + 2)]), 32'h33);
        check("wr_count", 32'(n_wt - s_wt), 1);
        check("wr_lat", 32'(wt_cyc - lstrobe), 2);
        check("wr_addr", 32'(cmd_addr), 32'h000010);
        check("wr_len", 32'(cmd_len), 3);
        check("wr_no_rt", 32'(n_rt - s_rt), 0);

        // Busy hold with an overrun byte during the wait
        cmd_busy = 1'b1;
        snap();
        send(8'h55); send(8'hAA); send(8'h12); send(8'h34); send(8'h56);
        send(8'h01); send(8'h77);
        idle(50);
        send(8'h99);
        idle(49);
        check("busy_hold", 32'(n_wt - s_wt), 0);
        check("ovr_code", 32'(err_code), 5);
        check("ovr_count", 32'(n_err - s_err), 1);
        cmd_busy = 1'b0;
        fall_cyc = cyc;
        idle(5);
        check("busy_trig", 32'(n_wt - s_wt), 1);
        check("busy_lat", 32'(wt_cyc - fall_cyc), 1);
        check("busy_addr", 32'(cmd_addr), 32'h123456);
        check("busy_len", 32'(cmd_len), 1);
        check("busy_data", 32'(wlog[s_wr[7:0]]), 32'h77);

        // Bad command
        snap();
        send(8'h55); send(8'h77);
        idle(3);
        check("badcmd_code", 32'(err_code), 1);
        check("badcmd_err", 32'(n_err - s_err), 1);

        // Zero length
        snap();
        send(8'h55); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        send(8'h00);
        idle(3);
        check("len0_code", 32'(err_code), 2);
        check("len0_err", 32'(n_err - s_err), 1);

        // Length 17 exceeds MAX_LEN; length 16 must be accepted
        snap();
        send(8'h55); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        send(8'h11);
        idle(3);
        check("len17_code", 32'(err_code), 2);
        check("len17_err", 32'(n_err - s_err), 1);
        check("bad_no_trig", 32'(n_rt - s_rt + n_wt - s_wt), 0);
        snap();
        send(8'h55); send(8'hA5); send(8'h00); send(8'h00); send(8'h07);
        send(8'h10);
        idle(3);
        check("len16_rd", 32'(n_rt - s_rt), 1);
        check("len16_len", 32'(cmd_len), 16);
        check("len16_noerr", 32'(n_err - s_err), 0);

        // FIFO full at the second payload byte
        snap();
        send(8'h55); send(8'hAA); send(8'h00); send(8'h00); send(8'h20);
        send(8'h03); send(8'h11);
        wfifo_full = 1'b1;
        send(8'h22);
        wfifo_full = 1'b0;
        idle(3);
        check("ovf_code", 32'(err_code), 3);
        check("ovf_clr", 32'(n_clr - s_clr), 1);
        check("ovf_pushes", 32'(n_wr - s_wr), 1);
        check("ovf_no_wt", 32'(n_wt - s_wt), 0);

        // Recovery frame
        snap();
        send(8'h55); send(8'hAA); send(8'h00); send(8'h00); send(8'h30);
        send(8'h02); send(8'hAB); send(8'hCD);
        idle(5);
        check("rec_wt", 32'(n_wt - s_wt), 1);
        check("rec_d1", 32'(wlog[8'(s_wr + 1)]), 32'hCD);
        check("rec_addr", 32'(cmd_addr), 32'h000030);
        check("rec_noerr", 32'(n_err - s_err), 0);

        // Timeout after the address bytes
        snap();
        send(8'h55); send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
        lstrobe = strobe_cyc;
        idle(TO + 10);
        check("to_code", 32'(err_code), 4);
        check("to_err", 32'(n_err - s_err), 1);
        check("to_time", 32'(err_cyc - lstrobe), TO + 1);
        check("to_no_clr", 32'(n_clr - s_clr), 0);
        check("to_no_rt", 32'(n_rt - s_rt), 0);

        // Timeout inside DATA flushes the FIFO
        snap();
        send(8'h55); send(8'hAA); send(8'h00); send(8'h00); send(8'h00);
        send(8'h02); send(8'h11);
        idle(TO + 10);
        check("to_data_err", 32'(n_err - s_err), 1);
        check("to_data_clr", 32'(n_clr - s_clr), 1);
        check("to_data_no_wt", 32'(n_wt - s_wt), 0);

        // Strobe on the expiry cycle wins
        snap();
        send(8'h55); send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
        idle(TO - 1);
        send(8'h04);
        idle(5);
        check("exp_strobe_noerr", 32'(n_err - s_err), 0);
        check("exp_strobe_rt", 32'(n_rt - s_rt), 1);

        // Reset mid-DATA
        send(8'h55); send(8'hAA); send(8'h00); send(8'h00); send(8'h40);
        send(8'h04); send(8'h11); send(8'h22);
        rst = 1'b1;
        #1;
        check("mrst_wr_en", 32'(wfifo_wr_en), 0);
        check("mrst_wdata", 32'(wfifo_wr_data), 0);
        check("mrst_addr", 32'(cmd_addr), 0);
        check("mrst_len", 32'(cmd_len), 0);
        check("mrst_err", {28'd0, err_valid, err_code}, 0);
        check("mrst_pulses", {29'd0, wfifo_clr, wr_trig, rd_trig}, 0);
        idle(2);
        rst = 1'b0;
        idle(2);
        snap();
        send(8'h33); send(8'h44);
        send(8'h55); send(8'hA5); send(8'h0A); send(8'h0B); send(8'h0C);
        send(8'h02);
        idle(5);
        check("post_rst_rt", 32'(n_rt - s_rt), 1);
        check("post_rst_addr", 32'(cmd_addr), 32'h0A0B0C);
        check("post_rst_noerr", 32'(n_err - s_err), 0);
        check("post_rst_nowr", 32'(n_wr - s_wr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
